// File: rtl/igual_2b2b_sweep.sv
// igual_2b2b_sweep
// ----------------
// Stimulus driver and checker for the 2-bit equality comparator igual_2b2b
// (the comparator drives out = 1 when {A,B} == {C,D}). A start pulse makes
// this block sweep all 16 {A,B,C,D} vectors into the comparator. Each
// vector is held for SETTLE cycles and then for one sample cycle. At the
// end of that sample cycle the block reads the comparator's result and
// checks it against the expected equality.
//
// Parameters
//   SETTLE      cycles each vector is held before sampling (1..15)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset; takes priority over start
//   start       sweep request; only honoured in IDLE or DONE
//   eq_in       comparator result, sampled at the end of the SAMPLE cycle
//   A,B,C,D     comparator operands, {A,B,C,D} = current vector index
//   busy        high while a sweep is in progress (SETTLE / SAMPLE)
//   done        high once a sweep has finished, until the next start
//   pass        while done: no mismatches and exactly four equal vectors
//   err_count   number of mismatching vectors in the current/last sweep
//   hit_count   number of vectors where eq_in was 1
//   fail_valid  at least one mismatch has been recorded
//   fail_idx    index of the first mismatching vector (0 if none)

module igual_2b2b_sweep #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       eq_in,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [4:0] hit_count,
  output logic       fail_valid,
  output logic [3:0] fail_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  // The wait counter counts down to zero. Loading SETTLE-1 therefore
  // gives exactly SETTLE cycles in the SETTLE state.
  localparam logic [3:0] WAIT_RELOAD = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] idx;
  logic [3:0] wait_cnt;
  logic       expected;

  // The operands come straight from the vector index register. They only
  // change on the edge that moves to a new vector, so the comparator always
  // sees a stable input for the full SETTLE+1 cycles of that vector.
  assign {A, B, C, D} = idx;

  // Status flags are decoded from the state register alone. They therefore
  // switch on the same edge as the state itself.
  assign busy = (state == S_SETTLE) || (state == S_SAMPLE);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == 5'd0) && (hit_count == 5'd4);

  // This is the reference model: an equal operand pair means bit A matches
  // bit C and bit B matches bit D.
  assign expected = (idx[3] == idx[1]) && (idx[2] == idx[0]);

  // Sweep sequencer and result accumulation.
  // A new start always clears all results before the first vector is
  // driven, so the results never mix data from two sweeps. Neither counter
  // can wrap: it sees at most 16 increments and is 5 bits wide.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= 4'd0;
      wait_cnt   <= 4'd0;
      err_count  <= 5'd0;
      hit_count  <= 5'd0;
      fail_valid <= 1'b0;
      fail_idx   <= 4'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_SETTLE;
            idx        <= 4'd0;
            wait_cnt   <= WAIT_RELOAD;
            err_count  <= 5'd0;
            hit_count  <= 5'd0;
            fail_valid <= 1'b0;
            fail_idx   <= 4'd0;
          end
        end

        S_SETTLE: begin
          if (wait_cnt == 4'd0) begin
            state <= S_SAMPLE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        S_SAMPLE: begin
          if (eq_in != expected) begin
            err_count <= err_count + 5'd1;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_idx   <= idx;
            end
          end
          if (eq_in) begin
            hit_count <= hit_count + 5'd1;
          end
          if (idx == 4'd15) begin
            state <= S_DONE;
          end else begin
            idx      <= idx + 4'd1;
            wait_cnt <= WAIT_RELOAD;
            state    <= S_SETTLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_igual_2b2b_sweep.sv
// tb_igual_2b2b_sweep
// -------------------
// Directed bench for igual_2b2b_sweep. It uses two instances:
//   u_s1 : SETTLE=1. Covers the golden, stuck-at-0, stuck-at-1, reset-abort,
//          restart-from-DONE and held-start cases.
//   u_s3 : SETTLE=3. Covers sweep length, operand hold time, and start
//          pulses issued while busy.
// For each instance the bench drives eq_in from a behavioural comparator,
// or ties it to a constant, as selected by a per-instance mode variable.

module tb_igual_2b2b_sweep;

  localparam int MODE_GOLDEN = 0;
  localparam int MODE_TIED0  = 1;
  localparam int MODE_TIED1  = 2;

  logic clk;

  logic       rst1, start1, eq1;
  logic       a1, b1, c1, d1, busy1, done1, pass1, fv1;
  logic [4:0] err1, hit1;
  logic [3:0] fidx1;
  int         mode1;

  logic       rst3, start3, eq3;
  logic       a3, b3, c3, d3, busy3, done3, pass3, fv3;
  logic [4:0] err3, hit3;
  logic [3:0] fidx3;
  int         mode3;

  int n_checks;
  int n_fail;
  int cyc;

  igual_2b2b_sweep #(.SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst1), .start(start1), .eq_in(eq1),
    .A(a1), .B(b1), .C(c1), .D(d1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .hit_count(hit1),
    .fail_valid(fv1), .fail_idx(fidx1)
  );

  igual_2b2b_sweep #(.SETTLE(3)) u_s3 (
    .clk(clk), .rst(rst3), .start(start3), .eq_in(eq3),
    .A(a3), .B(b3), .C(c3), .D(d3),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .hit_count(hit3),
    .fail_valid(fv3), .fail_idx(fidx3)
  );

  // Comparator stand-in: a golden 2-bit equality, or a stuck output.
  always_comb begin
    eq1 = 1'b0;
    case (mode1)
      MODE_GOLDEN: eq1 = ({a1, b1} == {c1, d1});
      MODE_TIED1:  eq1 = 1'b1;
      default:     eq1 = 1'b0;
    endcase
    eq3 = 1'b0;
    case (mode3)
      MODE_GOLDEN: eq3 = ({a3, b3} == {c3, d3});
      MODE_TIED1:  eq3 = 1'b1;
      default:     eq3 = 1'b0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expected value, counts the
  // comparison, and reports it if they differ.
  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start on the SETTLE=1 instance. Then counts the clocks until
  // done, with a bound so that the bench cannot hang.
  task automatic apply_stimulus(input string tag);
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    check_output({tag, "_busy_after_start"}, busy1, 1'b1);
    cyc = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (done1) begin
        cyc = n;
        break;
      end
    end
    check_output({tag, "_sweep_clocks"}, cyc, 32);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mode1    = MODE_GOLDEN;
    mode3    = MODE_GOLDEN;
    rst1     = 1'b1;
    rst3     = 1'b1;
    start1   = 1'b0;
    start3   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_s1_all_zero",
                 {a1, b1, c1, d1, busy1, done1, pass1, err1, hit1, fv1, fidx1}, 0);
    check_output("reset_s3_all_zero",
                 {a3, b3, c3, d3, busy3, done3, pass3, err3, hit3, fv3, fidx3}, 0);
    rst1 = 1'b0;
    rst3 = 1'b0;

    $display("[TB] golden comparator, SETTLE=1");
    apply_stimulus("golden");
    check_output("golden_pass", pass1, 1'b1);
    check_output("golden_err", err1, 5'd0);
    check_output("golden_hit", hit1, 5'd4);
    check_output("golden_fail_valid", fv1, 1'b0);
    check_output("golden_fail_idx", fidx1, 4'd0);
    check_output("golden_operands_done", {a1, b1, c1, d1}, 4'hF);
    check_output("golden_busy_done", busy1, 1'b0);

    $display("[TB] eq_in stuck at 0");
    mode1 = MODE_TIED0;
    apply_stimulus("tied0");
    check_output("tied0_err", err1, 5'd4);
    check_output("tied0_hit", hit1, 5'd0);
    check_output("tied0_pass", pass1, 1'b0);
    check_output("tied0_fail_valid", fv1, 1'b1);
    check_output("tied0_fail_idx", fidx1, 4'd0);

    $display("[TB] eq_in stuck at 1");
    mode1 = MODE_TIED1;
    apply_stimulus("tied1");
    check_output("tied1_err", err1, 5'd12);
    check_output("tied1_hit", hit1, 5'd16);
    check_output("tied1_pass", pass1, 1'b0);
    check_output("tied1_fail_valid", fv1, 1'b1);
    check_output("tied1_fail_idx", fidx1, 4'd1);

    $display("[TB] restart from DONE with golden comparator");
    mode1 = MODE_GOLDEN;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    check_output("restart_busy", busy1, 1'b1);
    check_output("restart_cleared", {err1, hit1, fv1, fidx1}, 0);
    check_output("restart_operands", {a1, b1, c1, d1}, 4'h0);
    cyc = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (done1) begin
        cyc = n;
        break;
      end
    end
    check_output("restart_sweep_clocks", cyc, 32);
    check_output("restart_pass", pass1, 1'b1);

    $display("[TB] reset in the middle of a sweep");
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst1 = 1'b1;
    check_output("midsweep_busy_before_rst", busy1, 1'b1);
    @(posedge clk);
    #1 rst1 = 1'b0;
    check_output("midsweep_rst_all_zero",
                 {a1, b1, c1, d1, busy1, done1, pass1, err1, hit1, fv1, fidx1}, 0);
    @(posedge clk);
    #1;
    check_output("midsweep_stays_idle", {busy1, done1}, 2'b00);
    apply_stimulus("after_rst");
    check_output("after_rst_pass", pass1, 1'b1);
    check_output("after_rst_hit", hit1, 5'd4);

    $display("[TB] SETTLE=3 with start pulses while busy");
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    cyc = 0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1;
      if (n == 3) check_output("s3_operands_held", {a3, b3, c3, d3}, 4'h0);
      if (n == 4) check_output("s3_operands_next", {a3, b3, c3, d3}, 4'h1);
      if (n == 8) check_output("s3_operands_third", {a3, b3, c3, d3}, 4'h2);
      if (done3) begin
        cyc = n;
        break;
      end
      start3 = (n == 5) || (n == 40);
    end
    start3 = 1'b0;
    check_output("s3_sweep_clocks", cyc, 64);
    check_output("s3_pass", pass3, 1'b1);
    check_output("s3_hit", hit3, 5'd4);

    $display("[TB] start held high through DONE");
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    cyc = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (done1) begin
        cyc = n;
        break;
      end
    end
    check_output("held_sweep_clocks", cyc, 32);
    @(posedge clk);
    #1 start1 = 1'b0;
    check_output("held_done_one_cycle", {done1, busy1}, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/igual_2b2b_sweep.md
# igual_2b2b_sweep

Self-checking stimulus driver for the 2-bit equality comparator (`igual_2b2b`: out = 1 when AB == CD). On a `start` pulse it sweeps all 16 {A,B,C,D} combinations into the comparator, waits a programmable settle time per vector, and samples the comparator's `out`. It then checks that value against the expected equality and reports pass/fail, a mismatch count, a hit count and the first failing vector. It sits on the initiator side of the comparator interface, for on-chip self-test and bench use.

## Interface
- SETTLE, default 1, cycles each vector is held before sampling; legal range 1..15.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  sweep request; sampled only in IDLE or DONE.
- eq_in  input  1  comparator `out`, sampled in SAMPLE.
- A, B, C, D  output  1 each  comparator operands; {A,B,C,D} = idx[3:0].
- busy  output  1  high in SETTLE and SAMPLE.
- done  output  1  high in DONE.
- pass  output  1  valid while done: err_count==0 && hit_count==4.
- err_count  output  5  mismatches in current/last sweep, 0..16.
- hit_count  output  5  vectors with eq_in==1, 0..16.
- fail_valid  output  1  at least one mismatch recorded.
- fail_idx  output  4  index of first mismatching vector; 0 when fail_valid==0.

## Operation
- State machine: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: all outputs 0. start=1 → SETTLE; idx=0, err_count=hit_count=0, fail_valid=0, fail_idx=0, wait counter=SETTLE-1.
- SETTLE: drive {A,B,C,D}=idx. If wait counter==0 → SAMPLE; otherwise decrement.
- SAMPLE: expected = (A==C)&&(B==D).
  - eq_in != expected: err_count+1. If fail_valid==0, set fail_valid=1 and fail_idx=idx.
  - eq_in==1: hit_count+1.
  - idx==15 → DONE. Otherwise idx+1 → SETTLE and reload wait counter=SETTLE-1.
- DONE: done=1; pass valid. A..D stay at vector 15 (1111). Results hold until the next start.
  - start=1 → SETTLE with the same clearing as from IDLE.
- start while busy is ignored; there is no queuing.
- Counters cannot wrap: a sweep has at most 16 samples and both counters are 5 bits.
- Golden comparator: exactly 4 hits (0000, 0101, 1010, 1111), 0 errors.

## Timing
- Reset: the edge with rst=1 forces IDLE. Every output becomes 0: A..D, busy, done, pass, err_count, hit_count, fail_valid, fail_idx. rst has priority over start.
- Reset mid-sweep aborts the sweep; no partial results remain.
- Per vector: SETTLE cycles in SETTLE plus 1 cycle in SAMPLE. Operands change only on the edge entering SETTLE for a new idx.
- eq_in is sampled at the rising edge that ends the SAMPLE cycle. The operands have then been stable for SETTLE+1 cycles.
- Edge k=0 samples start=1. busy rises after edge 0. done rises after edge 16*(SETTLE+1); busy falls on the same edge.
  - SETTLE=1: done 32 clocks after start.
- Counter updates from the last SAMPLE are visible in the same cycle done first reads 1.
- start held high through DONE: a new sweep starts on the first DONE cycle, so done pulses for exactly 1 cycle.

## Test plan
- Golden `igual_2b2b` connected, SETTLE=1, start pulse → done after exactly 32 clocks; pass=1, err_count=0, hit_count=4, fail_valid=0, fail_idx=0; {A,B,C,D}=1111 in DONE.
- eq_in tied 0 → err_count=4, hit_count=0, pass=0, fail_valid=1, fail_idx=0.
- eq_in tied 1 → err_count=12, hit_count=16, pass=0, fail_idx=1 (vector 0001).
- SETTLE=3, golden DUT → done after 64 clocks, each operand held 4 cycles; extra start pulses at clocks 5 and 40 are ignored (the sweep ends at clock 64, not later).
- rst asserted for 1 cycle at clock 10 of a sweep → next cycle everything is 0 and state is IDLE. A new start gives a full clean 32-clock sweep with pass=1.
- From DONE after a failing sweep, swap to the golden DUT and pulse start → busy next cycle, counters and fail_valid cleared; final pass=1.
